// File: rtl/fastica_pkg.sv
// Shared types and helpers for the streaming FastICA kurtosis update.
// The UPDATE_SAT_EN macro (checked in the datapath files) selects saturating
// narrowing instead of two's-complement wrap.
package fastica_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int FRAC_WIDTH_DEF = 10;
  localparam int ONE_Q          = 1 << FRAC_WIDTH_DEF;

  // Clamp a wide signed value into the signed range of 'width' bits.
  // The caller keeps only the low 'width' bits of the result.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/fastica_dot_cube.sv
// Dot-product and cube stages of the FastICA update: p_i = w_i*z_i,
// y = sum(p_i) >>> F, g = ((y*y >>> F) * y) >>> F, one sample per cycle.
// Narrowing of y and g saturates when UPDATE_SAT_EN is defined, else wraps.
module fastica_dot_cube
  import fastica_pkg::*;
#(
  parameter int N          = 7,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [N*DATA_WIDTH-1:0]      w,
  input  logic [N*DATA_WIDTH-1:0]      z,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] g
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(N + 1);
  localparam int CW = PW + DW;

  logic signed [PW-1:0] p_q [N];
  logic signed [PW-1:0] p_d [N];
  logic signed [DW-1:0] y_q, y_d;
  logic signed [DW-1:0] g_q, g_d;
  logic                 v1_q, v1_d;
  logic                 v2_q, v2_d;
  logic                 v3_q, v3_d;
  logic signed [SW-1:0] sum;
  logic signed [PW-1:0] yy;
  logic signed [CW-1:0] yyy;

  // Next values for products, dot-product result, cube and the valid chain.
  always_comb begin
    v1_d = in_valid & ~flush;
    v2_d = v1_q & ~flush;
    v3_d = v2_q & ~flush;
    sum  = '0;
    yy   = '0;
    yyy  = '0;
    for (int i = 0; i < N; i++) begin
      p_d[i] = PW'($signed(w[i*DW +: DW])) * PW'($signed(z[i*DW +: DW]));
    end
    for (int i = 0; i < N; i++) begin
      sum = sum + SW'(p_q[i]);
    end
    yy  = PW'(y_q) * PW'(y_q);
    yyy = CW'(yy >>> FRAC_WIDTH) * CW'(y_q);
`ifdef UPDATE_SAT_EN
    y_d = DW'(sat_narrow(64'(sum >>> FRAC_WIDTH), DW));
    g_d = DW'(sat_narrow(64'(yyy >>> FRAC_WIDTH), DW));
`else
    y_d = DW'(sum >>> FRAC_WIDTH);
    g_d = DW'(yyy >>> FRAC_WIDTH);
`endif
  end

  // Pipeline registers; reset clears data as well as valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        p_q[i] <= '0;
      end
      y_q  <= '0;
      g_q  <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        p_q[i] <= p_d[i];
      end
      y_q  <= y_d;
      g_q  <= g_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  assign out_valid = v3_q;
  assign g         = g_q;

endmodule

// File: rtl/fastica_update_stream.sv
// Streaming FastICA kurtosis update:
//   W+ = (1/2^logm) * sum_k z_k*(w'z_k)^3 - 3w
// One whitened N-vector is accepted per valid/ready beat; the result is
// offered on a valid/ready output. Define UPDATE_SAT_EN for saturating
// narrowing of y, g, accumulators and m_w (default: wrap).
//
// state | meaning
// IDLE  | waiting for start, w/logm not latched
// ACCUM | accepting 2^logm sample beats
// DRAIN | last beat accepted, pipeline flushing into accumulators
// FINAL | accumulators complete, m_w computed this cycle
// DONE  | m_w valid, holding until m_ready
module fastica_update_stream
  import fastica_pkg::*;
#(
  parameter int N          = 7,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 10,
  parameter int LOGM_MAX   = 10,
  parameter int ACC_WIDTH  = DATA_WIDTH + LOGM_MAX + 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [$clog2(LOGM_MAX+1)-1:0]    logm_in,
  input  logic [N*DATA_WIDTH-1:0]          w_in,
  output logic                             busy,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [N*DATA_WIDTH-1:0]          s_z,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [N*DATA_WIDTH-1:0]          m_w
);

  localparam int DW   = DATA_WIDTH;
  localparam int PW   = 2 * DW;
  localparam int LW   = $clog2(LOGM_MAX + 1);
  localparam int CNTW = LOGM_MAX + 1;
  localparam int FW   = ACC_WIDTH + 2;

  state_t                      state_q, state_d;
  logic [CNTW-1:0]             beat_cnt_q, beat_cnt_d;
  logic [1:0]                  drain_cnt_q, drain_cnt_d;
  logic [LW-1:0]               logm_q, logm_d, logm_c;
  logic [N*DW-1:0]             w_q, w_d;
  logic [N*DW-1:0]             zin_q, zin_d;
  logic [N*DW-1:0]             z1_q, z1_d;
  logic [N*DW-1:0]             z2_q, z2_d;
  logic [N*DW-1:0]             z3_q, z3_d;
  logic [N*DW-1:0]             m_w_q, m_w_d;
  logic                        vin_q, vin_d;
  logic signed [ACC_WIDTH-1:0] acc_q [N];
  logic signed [ACC_WIDTH-1:0] acc_d [N];
  logic                        g_valid;
  logic signed [DW-1:0]        g;
  logic signed [PW-1:0]        zg;
  logic signed [ACC_WIDTH:0]   acc_sum;
  logic signed [FW-1:0]        fin;

  // Beats are registered once before entering the dot/cube stages so the
  // product stage lands one edge after the accepting edge.
  fastica_dot_cube #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_dot_cube (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (vin_q),
    .w         (w_q),
    .z         (zin_q),
    .out_valid (g_valid),
    .g         (g)
  );

  // FSM next state, beat/drain down-counters, z alignment, accumulators, result.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    logm_d      = logm_q;
    w_d         = w_q;
    zin_d       = s_z;
    z1_d        = zin_q;
    z2_d        = z1_q;
    z3_d        = z2_q;
    vin_d       = 1'b0;
    acc_d       = acc_q;
    m_w_d       = m_w_q;
    zg          = '0;
    acc_sum     = '0;
    fin         = '0;
    logm_c      = (logm_in > LW'(LOGM_MAX)) ? LW'(LOGM_MAX) : logm_in;

    if (g_valid) begin
      for (int i = 0; i < N; i++) begin
        zg      = PW'($signed(z3_q[i*DW +: DW])) * PW'(g);
        acc_sum = (ACC_WIDTH+1)'(acc_q[i]) + (ACC_WIDTH+1)'(zg >>> FRAC_WIDTH);
`ifdef UPDATE_SAT_EN
        acc_d[i] = ACC_WIDTH'(sat_narrow(64'(acc_sum), ACC_WIDTH));
`else
        acc_d[i] = ACC_WIDTH'(acc_sum);
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          logm_d     = logm_c;
          w_d        = w_in;
          beat_cnt_d = (CNTW'(1) << logm_c) - CNTW'(1);
          for (int i = 0; i < N; i++) begin
            acc_d[i] = '0;
          end
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (s_valid) begin
          vin_d = 1'b1;
          if (beat_cnt_q == '0) begin
            drain_cnt_d = 2'd3;
            state_d     = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q - CNTW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 2'd0) begin
          state_d = FINAL;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      FINAL: begin
        for (int i = 0; i < N; i++) begin
          fin = FW'(acc_q[i] >>> logm_q)
              - ((FW'($signed(w_q[i*DW +: DW])) <<< 1) + FW'($signed(w_q[i*DW +: DW])));
`ifdef UPDATE_SAT_EN
          m_w_d[i*DW +: DW] = DW'(sat_narrow(64'(fin), DW));
`else
          m_w_d[i*DW +: DW] = DW'(fin);
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      vin_d   = 1'b0;
      for (int i = 0; i < N; i++) begin
        acc_d[i] = '0;
      end
    end
  end

  // State, counters, alignment registers and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      logm_q      <= '0;
      w_q         <= '0;
      zin_q       <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      z3_q        <= '0;
      m_w_q       <= '0;
      vin_q       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      logm_q      <= logm_d;
      w_q         <= w_d;
      zin_q       <= zin_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      z3_q        <= z3_d;
      m_w_q       <= m_w_d;
      vin_q       <= vin_d;
      for (int i = 0; i < N; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign s_ready = (state_q == ACCUM);
  assign m_valid = (state_q == DONE);
  assign m_w     = m_w_q;

endmodule
